// File: rtl/vdp18_pkg.sv
// Shared types and constants for the VDP18 VRAM access scheduler.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Pixel and line positions are 9-bit values. The scheduler compares them as raw
// unsigned patterns. This puts negative positions (raw >= 256) outside the active
// area, and the sprite slot window becomes raw 256..303.
package vdp18_pkg;

  typedef enum logic [1:0] {
    OPMODE_GRAPH1 = 2'd0,
    OPMODE_GRAPH2 = 2'd1,
    OPMODE_MULTIC = 2'd2,
    OPMODE_TEXTM  = 2'd3
  } opmode_t;

  typedef enum logic [3:0] {
    AC_NONE = 4'd0,
    AC_CPU  = 4'd1,
    AC_PNT  = 4'd2,
    AC_PCT  = 4'd3,
    AC_PGT  = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPTH = 4'd9,
    AC_SPTL = 4'd10
  } access_t;

  // Active display geometry
  localparam logic [8:0] ACTIVE_W_GFX   = 9'd256;
  localparam logic [8:0] ACTIVE_W_TXT   = 9'd240;
  localparam logic [8:0] ACTIVE_LINES   = 9'd192;

  // Sprite fetch window: 4 sprites x 6 accesses x 2 pixels per slot
  localparam logic [8:0] SPR_SLOT_START = 9'd256;
  localparam logic [8:0] SPR_SLOT_END   = 9'd304;
  localparam logic [4:0] SPR_SEQ_LEN    = 5'd6;

  // Access issued at a given step of the per-sprite fetch sequence
  function automatic access_t spr_seq_access(input logic [2:0] step);
    access_t acc;
    case (step)
      3'd0:    acc = AC_SATY;
      3'd1:    acc = AC_SATX;
      3'd2:    acc = AC_SATN;
      3'd3:    acc = AC_SATC;
      3'd4:    acc = AC_SPTH;
      default: acc = AC_SPTL;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/vdp18_access_sched_if.sv
// VRAM access handshake bundle: CPU request/grant plus the scheduled access strobe.
// Latency: n/a (wires only).
// Backpressure: the request is a level that the requester holds until cpu_ack_o pulses.
//
// Signals:
//   cpu_req_i     requester -> scheduler  CPU VRAM access request (level)
//   access_type_o scheduler -> requester  access scheduled for the current slot
//   clk_en_acc_o  scheduler -> requester  one-cycle access strobe per slot
//   cpu_ack_o     scheduler -> requester  one-cycle grant, coincident with the strobe
//   sprite_idx_o  scheduler -> requester  sprite number (VDP18_SPR_ACC_EN builds only)
interface vdp18_access_sched_if;
  import vdp18_pkg::*;

  logic       cpu_req_i;
  access_t    access_type_o;
  logic       clk_en_acc_o;
  logic       cpu_ack_o;
`ifdef VDP18_SPR_ACC_EN
  logic [1:0] sprite_idx_o;
`endif

  // Requester side (CPU port / testbench)
  modport master (
    output cpu_req_i,
`ifdef VDP18_SPR_ACC_EN
    input  sprite_idx_o,
`endif
    input  access_type_o,
    input  clk_en_acc_o,
    input  cpu_ack_o
  );

  // Scheduler side
  modport slave (
    input  cpu_req_i,
`ifdef VDP18_SPR_ACC_EN
    output sprite_idx_o,
`endif
    output access_type_o,
    output clk_en_acc_o,
    output cpu_ack_o
  );

endinterface

// File: rtl/vdp18_slot_decode.sv
// Combinational slot map: (opmode, slot index, area flags) -> scheduled access.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; a CPU slot decodes as AC_CPU, and the parent decides grant/none.
//
// Ports:
//   i_opmode     display mode
//   i_gfx_slot   slot index within a 4-slot group (graphics/multicolor)
//   i_txt_slot   mod-3 slot counter value (text mode)
//   i_active     slot lies in the active display area
//   i_spr_area   slot lies in the sprite fetch window   (VDP18_SPR_ACC_EN only)
//   i_spr_slot   slot number 0..23 inside that window   (VDP18_SPR_ACC_EN only)
//   o_access     scheduled access
//   o_sprite_idx sprite number for sprite accesses      (VDP18_SPR_ACC_EN only)
module vdp18_slot_decode
  import vdp18_pkg::*;
(
  input  opmode_t    i_opmode,
  input  logic [1:0] i_gfx_slot,
  input  logic [1:0] i_txt_slot,
  input  logic       i_active,
`ifdef VDP18_SPR_ACC_EN
  input  logic       i_spr_area,
  input  logic [4:0] i_spr_slot,
  output logic [1:0] o_sprite_idx,
`endif
  output access_t    o_access
);

  always_comb begin
    o_access = AC_CPU;
`ifdef VDP18_SPR_ACC_EN
    o_sprite_idx = 2'd0;
`endif
    if (i_active) begin
      case (i_opmode)
        OPMODE_TEXTM: begin
          case (i_txt_slot)
            2'd0:    o_access = AC_PNT;
            2'd1:    o_access = AC_PGT;
            default: o_access = AC_CPU;
          endcase
        end
        OPMODE_MULTIC: begin
          // Multicolor has no colour table; slot 1 is handed to the CPU instead
          case (i_gfx_slot)
            2'd0:    o_access = AC_PNT;
            2'd2:    o_access = AC_PGT;
            default: o_access = AC_CPU;
          endcase
        end
        default: begin
          case (i_gfx_slot)
            2'd0:    o_access = AC_PNT;
            2'd1:    o_access = AC_PCT;
            2'd2:    o_access = AC_PGT;
            default: o_access = AC_CPU;
          endcase
        end
      endcase
    end
`ifdef VDP18_SPR_ACC_EN
    else if (i_spr_area) begin
      o_access     = spr_seq_access(3'(i_spr_slot % SPR_SEQ_LEN));
      o_sprite_idx = 2'(i_spr_slot / SPR_SEQ_LEN);
    end
`endif
  end

endmodule

// File: rtl/vdp18_access_sched.sv
// VDP18 VRAM access scheduler: one access per 2-pixel slot, CPU granted in free slots.
// Latency: access_type_o updates one clk after the slot-start enable; the strobe and ack follow the slot-end enable by one clk.
// Backpressure: cpu_req_i is held by the requester; ungranted requests wait for the next CPU slot.
//
// Ports:
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   clk_en_5m37_i  pixel clock enable
//   opmode_i       display mode
//   num_pix_i      horizontal position, [8] is the LSB
//   num_line_i     vertical position, [8] is the LSB
//   reg_blank_i    display enable (0 = display disabled)
//   acc_if         request/grant/strobe bundle (slave side)
// Build option: define VDP18_SPR_ACC_EN to schedule sprite fetches at pixels 256..303
// and to drive acc_if.sprite_idx_o.
module vdp18_access_sched
  import vdp18_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clk_en_5m37_i,
  input  opmode_t             opmode_i,
  input  logic signed [0:8]   num_pix_i,
  input  logic signed [0:8]   num_line_i,
  input  logic                reg_blank_i,
  vdp18_access_sched_if.slave acc_if
);

  logic [8:0] w_pix_raw;
  logic [8:0] w_line_raw;
  logic       w_slot_start;
  logic       w_slot_end;
  logic       w_line_act;
  logic       w_active;
  logic [1:0] w_gfx_slot;
  logic [1:0] w_txt_slot;
  logic       w_cpu_slot;
  access_t    w_sched;

  access_t    r_access;
  logic       r_slot_open;
  logic       r_grant;
  logic       r_clk_en_acc;
  logic       r_cpu_ack;
  logic [1:0] r_txt_cnt;

  // Reinterpret the MSB-first positions as ordinary unsigned patterns.
  // Negative positions land at raw >= 256 and therefore fall outside the active area.
  assign w_pix_raw  = num_pix_i;
  assign w_line_raw = num_line_i;

  assign w_slot_start = clk_en_5m37_i & ~num_pix_i[8];
  assign w_slot_end   = clk_en_5m37_i &  num_pix_i[8];

  assign w_line_act = (w_line_raw < ACTIVE_LINES);
  assign w_active   = reg_blank_i & w_line_act &
                      (w_pix_raw < ((opmode_i == OPMODE_TEXTM) ? ACTIVE_W_TXT : ACTIVE_W_GFX));

  // num_pix_i[6] has weight 4 and num_pix_i[7] has weight 2, so this is (pix/2) mod 4
  assign w_gfx_slot = {num_pix_i[6], num_pix_i[7]};

  // The text counter restarts at column 0. That slot itself uses index 0.
  assign w_txt_slot = (w_pix_raw == 9'd0) ? 2'd0 : r_txt_cnt;

`ifdef VDP18_SPR_ACC_EN
  logic       w_spr_area;
  logic [4:0] w_spr_slot;
  logic [1:0] w_spr_idx;
  logic [1:0] r_sprite_idx;

  // Sprite fetches depend only on line and mode. reg_blank_i does not gate them.
  assign w_spr_area = w_line_act & (opmode_i != OPMODE_TEXTM) &
                      (w_pix_raw >= SPR_SLOT_START) & (w_pix_raw < SPR_SLOT_END);
  assign w_spr_slot = 5'((w_pix_raw - SPR_SLOT_START) >> 1);
`endif

  vdp18_slot_decode u_slot_decode (
    .i_opmode     (opmode_i),
    .i_gfx_slot   (w_gfx_slot),
    .i_txt_slot   (w_txt_slot),
    .i_active     (w_active),
`ifdef VDP18_SPR_ACC_EN
    .i_spr_area   (w_spr_area),
    .i_spr_slot   (w_spr_slot),
    .o_sprite_idx (w_spr_idx),
`endif
    .o_access     (w_sched)
  );

  assign w_cpu_slot = (w_sched == AC_CPU);

  // Mode, area and request are sampled only at the slot start. Later changes wait for
  // the next slot, so a slot in flight always completes as it was scheduled.
  // r_slot_open drops a slot-end that has no matching start, such as the first end
  // after reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_access     <= AC_NONE;
      r_slot_open  <= 1'b0;
      r_grant      <= 1'b0;
      r_clk_en_acc <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_txt_cnt    <= 2'd0;
    end else begin
      r_clk_en_acc <= 1'b0;
      r_cpu_ack    <= 1'b0;
      if (w_slot_start) begin
        r_slot_open <= 1'b1;
        r_txt_cnt   <= (w_txt_slot == 2'd2) ? 2'd0 : w_txt_slot + 2'd1;
        if (w_cpu_slot) begin
          r_access <= acc_if.cpu_req_i ? AC_CPU : AC_NONE;
          r_grant  <= acc_if.cpu_req_i;
        end else begin
          r_access <= w_sched;
          r_grant  <= 1'b0;
        end
      end else if (w_slot_end) begin
        r_slot_open  <= 1'b0;
        r_grant      <= 1'b0;
        r_clk_en_acc <= r_slot_open;
        r_cpu_ack    <= r_slot_open & r_grant;
      end
    end
  end

`ifdef VDP18_SPR_ACC_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sprite_idx <= 2'd0;
    end else if (w_slot_start) begin
      r_sprite_idx <= w_spr_idx;
    end
  end

  assign acc_if.sprite_idx_o = r_sprite_idx;
`endif

  assign acc_if.access_type_o = r_access;
  assign acc_if.clk_en_acc_o  = r_clk_en_acc;
  assign acc_if.cpu_ack_o     = r_cpu_ack;

endmodule

// File: doc/vdp18_access_sched.md
VDP18_ACCESS_SCHED -- requirements
Module: vdp18_access_sched

Interface
REQ-001 clk_i  in  1  system clock; all state on rising edge.
REQ-002 reset_n_i  in  1  asynchronous, active-low reset.
REQ-003 clk_en_5m37_i  in  1  pixel-clock enable, one clk_i cycle wide.
REQ-004 opmode_i  in  opmode_t  current display mode (TEXTM, GRAPH1, GRAPH2, MULTIC).
REQ-005 num_pix_i  in  signed 9 [0:8]  horizontal pixel position; [8] is the LSB.
REQ-006 num_line_i  in  signed 9 [0:8]  vertical line position; negative or ≥192 means vertical blank.
REQ-007 reg_blank_i  in  1  display enable; 0 means display disabled.
REQ-008 cpu_req_i  in  1  CPU VRAM access request; level, held until acknowledged.
REQ-009 access_type_o  out  access_t  access scheduled for the current slot.
REQ-010 clk_en_acc_o  out  1  access strobe, one clk_i cycle per slot.
REQ-011 cpu_ack_o  out  1  one-cycle grant pulse, coincident with clk_en_acc_o in a granted CPU slot.

Function
REQ-012 A slot shall be 2 pixel enables long: it starts on the enable where num_pix_i[8]=0 and ends on the enable where num_pix_i[8]=1.
REQ-013 access_type_o shall be registered, shall update on the slot-start enable, and shall hold until the next slot start.
REQ-014 clk_en_acc_o shall go high for exactly one clk_i cycle, in the cycle after the slot-end enable.
REQ-015 Display area is active when reg_blank_i=1, num_line_i is in 0..191, and num_pix_i is in 0..255 (graphics/multicolor modes) or 0..239 (text mode).
REQ-016 In the active area, graphics I/II shall use the slot index num_pix_i[6:7]: 0 = AC_PNT, 1 = AC_PCT, 2 = AC_PGT, 3 = CPU.
REQ-017 In the active area, multicolor mode shall use 0 = AC_PNT, 1 = CPU, 2 = AC_PGT, 3 = CPU.
REQ-018 Text mode shall use a 2-bit mod-3 slot counter: it clears at the slot start where num_pix_i=0, then steps 0 = AC_PNT, 1 = AC_PGT, 2 = CPU, and wraps 2→0.
REQ-019 Outside the active area, every slot shall be a CPU slot, except as set out in REQ-026.
REQ-020 In a CPU slot with cpu_req_i=1 sampled at slot start, the block shall output access_type_o=AC_CPU and pulse cpu_ack_o together with clk_en_acc_o.
REQ-021 In a CPU slot with cpu_req_i=0, access_type_o shall be AC_NONE and no ack shall be issued.
REQ-022 If cpu_req_i falls mid-slot, the grant shall still complete; if it rises mid-slot, it shall wait for the next CPU slot.
REQ-023 A change of opmode_i or reg_blank_i shall take effect at the next slot start; an in-flight slot is never truncated.
REQ-024 If clk_en_5m37_i is held low, all outputs shall freeze; clk_en_acc_o and cpu_ack_o shall stay low.

Reset
REQ-025 While reset_n_i=0: access_type_o=AC_NONE, clk_en_acc_o=0, cpu_ack_o=0, text counter=0. After release, the first update shall occur on the first slot-start enable; a slot interrupted by reset shall be discarded, with no strobe or ack.

Configuration
REQ-026 With VDP18_SPR_ACC_EN defined, and num_line_i in 0..191 with opmode_i≠TEXTM:
  - Slots at num_pix_i 256..303 (24 slots) shall carry 4 sprites × the sequence AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL.
  - The sprite index sprite_idx_o (out, 2 bits) shall be valid with each access.
REQ-027 Without VDP18_SPR_ACC_EN, those slots shall be CPU slots and sprite_idx_o shall not exist.

Structure
REQ-028 access_t, including AC_NONE, AC_CPU, AC_PNT, AC_PCT, AC_PGT and the sprite codes, shall live in vdp18_pkg, as shall opmode_t and the constants for active width (256/240) and sprite slot start (256).
REQ-029 One sub-module, vdp18_slot_decode, is natural: a combinational mapping of (opmode, slot index, area flags) to access_t. Counters and the handshake shall stay in the parent.

Verification
REQ-030 GRAPH1, active line 10, cpu_req_i=0, pixels 0..7 → access_type_o sequence PNT, PCT, PGT, NONE with 4 clk_en_acc_o pulses.
REQ-031 TEXTM, pixels 0..11 with cpu_req_i=1 → PNT, PGT, CPU, PNT, PGT, CPU; cpu_ack_o pulses at slots 2 and 5 only.
REQ-032 MULTIC, cpu_req_i=1, pixels 0..7 → PNT, CPU(ack), PGT, CPU(ack).
REQ-033 num_line_i=200 or reg_blank_i=0, cpu_req_i=1 → every slot AC_CPU with ack; no PNT/PCT/PGT issued.
REQ-034 SPR_EN build, GRAPH2, line 50, pixels 256..303 → 24 accesses, SATY..SPTL repeated, sprite_idx_o 0,0..0,1..3; non-SPR build → all CPU.
REQ-035 Assert reset_n_i=0 on the cycle after the slot-start enable of a granted CPU slot → no cpu_ack_o; outputs at reset values; normal schedule resumes at the next slot start after release.
